// File: rtl/vram_port_arbiter_if.sv
// Requester-side bundle of the VRAM port A arbiter: two request/grant channels
// plus the shared read-return bus and the ready flag.
interface vram_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, ready
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, ready
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Round-robin arbiter sharing VRAM port A between the CPU register path (id 0)
// and the fill/scroll engine (id 1), with tagged read-return pipeline.
module vram_port_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 32,
    parameter int RD_LAT      = 2,
    parameter int INIT_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset_a,
    vram_port_arbiter_if.slave   bus,
    output logic [ADDR_W-1:0]    o_bram_addr,
    output logic [DATA_W-1:0]    o_bram_din,
    output logic                 o_bram_we,
    input  logic [DATA_W-1:0]    i_bram_dout
);
    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

    typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_ready;

    logic              r_rr_vld;
    logic              r_rr_ptr;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_acc;
    logic              w_id;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    logic [RD_LAT:0]   r_tag_v;
    logic [RD_LAT:0]   r_tag_id;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_bram_addr;
    logic [DATA_W-1:0] r_bram_din;
    logic              r_bram_we;

    // INIT/RUN next-state: INIT counts settle cycles, RUN is sticky until reset
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_INIT: begin
                if (r_cnt == INIT_LAST) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_INIT;
        endcase
    end

    // FSM state, settle counter and ready flag
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == S_RUN);
        end
    end

    // Grant decision: the id that did not win last time takes a tie; req 0 takes the first tie
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_ready && bus.req0 && bus.req1) begin
            if (r_rr_vld && !r_rr_ptr) begin
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = 1'b1;
            end
        end else if (r_ready) begin
            w_gnt0 = bus.req0;
            w_gnt1 = bus.req1;
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign w_acc   = w_gnt0 | w_gnt1;
    assign w_id    = w_gnt1;
    assign w_we    = w_id ? bus.we1    : bus.we0;
    assign w_addr  = w_id ? bus.addr1  : bus.addr0;
    assign w_wdata = w_id ? bus.wdata1 : bus.wdata0;

    // BRAM command registers, round-robin pointer and read-tag shift register
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            r_bram_addr <= '0;
            r_bram_din  <= '0;
            r_bram_we   <= 1'b0;
            r_rr_vld    <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_tag_v     <= '0;
            r_tag_id    <= '0;
        end else begin
            r_bram_we <= w_acc & w_we;
            if (w_acc) begin
                r_bram_addr <= w_addr;
                r_bram_din  <= w_wdata;
                r_rr_vld    <= 1'b1;
                r_rr_ptr    <= w_id;
            end
            r_tag_v  <= {r_tag_v[RD_LAT-1:0], w_acc & ~w_we};
            r_tag_id <= {r_tag_id[RD_LAT-1:0], w_id};
        end
    end

    // Read return: the oldest tag lines up with valid BRAM dout; rdata holds between strobes
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rvalid0 <= r_tag_v[RD_LAT] & ~r_tag_id[RD_LAT];
            r_rvalid1 <= r_tag_v[RD_LAT] &  r_tag_id[RD_LAT];
            if (r_tag_v[RD_LAT]) begin
                r_rdata <= i_bram_dout;
            end
        end
    end

    assign bus.gnt0    = w_gnt0;
    assign bus.gnt1    = w_gnt1;
    assign bus.rvalid0 = r_rvalid0;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rdata   = r_rdata;
    assign bus.ready   = r_ready;
    assign o_bram_addr = r_bram_addr;
    assign o_bram_din  = r_bram_din;
    assign o_bram_we   = r_bram_we;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: BRAM model, a spec-level scoreboard checked every
// cycle, a grant table, hand-written corner sequences and a random phase.
module tb_vram_port_arbiter;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int IC = 3;

    logic          clk = 1'b0;
    logic          reset_a = 1'b0;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          bram_we;
    logic [DW-1:0] bram_dout;

    vram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .INIT_CYCLES(IC)) dut (
        .clk         (clk),
        .reset_a     (reset_a),
        .bus         (bus),
        .o_bram_addr (bram_addr),
        .o_bram_din  (bram_din),
        .o_bram_we   (bram_we),
        .i_bram_dout (bram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 32'hA500_0000 | {21'd0, a};
    endfunction

    // BRAM port A: write commits at the edge it is sampled, reads are RL edges deep
    logic [DW-1:0] bmem [2048];
    bit            bvld [2048];
    logic [DW-1:0] pipe [RL];
    assign bram_dout = pipe[RL-1];
    always @(posedge clk) begin
        pipe[0] <= bvld[bram_addr] ? bmem[bram_addr] : init_val(bram_addr);
        for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
        if (bram_we) begin
            bmem[bram_addr] <= bram_din;
            bvld[bram_addr] <= 1'b1;
        end
    end

    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] data;
    } resp_t;

    typedef struct {
        logic r0;
        logic r1;
        logic g0;
        logic g1;
    } vec_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            rc = 0;
    logic          has_last = 1'b0;
    logic          last = 1'b0;
    logic [DW-1:0] smem [2048];
    resp_t         rq[$];
    logic          pend_we = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic [DW-1:0] pend_din = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic          acc0 = 1'b0;
    logic          acc1 = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (reset_a) rc = 0;
        else if (rc < 1000) rc++;
    endtask

    // Scoreboard: sample at negedge, predict grants, record accepts and their effects
    task automatic mon();
        logic          eg0, eg1, ev0, ev1, eid, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (reset_a) begin
            chk("rst_gnt", {30'd0, bus.gnt0, bus.gnt1}, 32'd0);
            chk("rst_rvalid", {30'd0, bus.rvalid0, bus.rvalid1}, 32'd0);
            chk("rst_ready", {31'd0, bus.ready}, 32'd0);
            chk("rst_we", {31'd0, bram_we}, 32'd0);
            chk("rst_rdata", bus.rdata, 32'd0);
            chk("rst_addr", {21'd0, bram_addr}, 32'd0);
            chk("rst_din", bram_din, 32'd0);
            rq.delete();
            pend_we   = 1'b0;
            has_last  = 1'b0;
            last      = 1'b0;
            exp_rdata = '0;
        end else begin
            chk("bram_we", {31'd0, bram_we}, {31'd0, pend_we});
            if (pend_we) begin
                chk("bram_addr", {21'd0, bram_addr}, {21'd0, pend_addr});
                chk("bram_din", bram_din, pend_din);
            end
            ev0 = 1'b0;
            ev1 = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                ev0 = ~rq[0].id;
                ev1 = rq[0].id;
                exp_rdata = rq[0].data;
                void'(rq.pop_front());
            end
            chk("rvalid0", {31'd0, bus.rvalid0}, {31'd0, ev0});
            chk("rvalid1", {31'd0, bus.rvalid1}, {31'd0, ev1});
            chk("rdata", bus.rdata, exp_rdata);
            chk("ready", {31'd0, bus.ready}, (rc >= IC) ? 32'd1 : 32'd0);
            eg0 = 1'b0;
            eg1 = 1'b0;
            if (rc >= IC) begin
                if (bus.req0 && bus.req1) begin
                    eid = has_last ? ~last : 1'b0;
                    eg0 = ~eid;
                    eg1 = eid;
                end else begin
                    eg0 = bus.req0;
                    eg1 = bus.req1;
                end
            end
            chk("gnt0", {31'd0, bus.gnt0}, {31'd0, eg0});
            chk("gnt1", {31'd0, bus.gnt1}, {31'd0, eg1});
            pend_we = 1'b0;
            if (eg0 || eg1) begin
                eid = eg1;
                ewe = eid ? bus.we1 : bus.we0;
                ea  = eid ? bus.addr1 : bus.addr0;
                ed  = eid ? bus.wdata1 : bus.wdata0;
                has_last = 1'b1;
                last     = eid;
                if (ewe) begin
                    smem[ea]  = ed;
                    pend_we   = 1'b1;
                    pend_addr = ea;
                    pend_din  = ed;
                end else begin
                    rq.push_back('{due: cyc + RL + 2, id: eid, data: smem[ea]});
                end
                acc0 = eg0;
                acc1 = eg1;
            end
        end
    endtask

    task automatic drive(input int i, input logic r, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (i == 0) begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            mon();
            step();
        end
    endtask

    task automatic do_reset();
        reset_a = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        mon();
        step();
        mon();
        step();
        reset_a = 1'b0;
    endtask

    // Holds a request until accepted; returns just after the accept edge with req dropped
    task automatic issue(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic got;
        got = 1'b0;
        drive(i, 1'b1, we, a, d);
        for (int k = 0; k < 20; k++) begin
            mon();
            if ((i == 0 && acc0) || (i == 1 && acc1)) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk("issue_grant", {31'd0, got}, 32'd1);
        step();
        drive(i, 1'b0, 1'b0, '0, '0);
    endtask

    logic [AW-1:0] ra;
    logic          prev_g0;
    logic          got;
    int            cnt;
    logic          rq_on [2];
    vec_t          vt [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 2048; a++) smem[a] = init_val(AW'(a));
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        #2;

        // T1: request held from cycle 0, first grant and ready at cycle IC
        do_reset();
        drive(0, 1'b1, 1'b0, 11'h005, '0);
        for (int k = 0; k <= IC; k++) begin
            mon();
            chk("T1_gnt0", {31'd0, bus.gnt0}, (k == IC) ? 32'd1 : 32'd0);
            chk("T1_ready", {31'd0, bus.ready}, (k == IC) ? 32'd1 : 32'd0);
            if (k < IC) step();
        end
        step();
        drive(0, 1'b0, 1'b0, '0, '0);
        run(6);

        // T2: read latency and data for req 0
        issue(1, 1'b1, 11'h010, 32'hDEAD_BEEF);
        run(2);
        issue(0, 1'b0, 11'h010, '0);
        for (int k = 1; k <= 4; k++) begin
            mon();
            chk("T2_rvalid0", {31'd0, bus.rvalid0}, (k == 4) ? 32'd1 : 32'd0);
            chk("T2_rvalid1", {31'd0, bus.rvalid1}, 32'd0);
            if (k == 4) chk("T2_rdata", bus.rdata, 32'hDEAD_BEEF);
            step();
        end

        // T4: write then read of the same address on the next cycle
        issue(1, 1'b1, 11'h7FF, 32'h1234_5678);
        drive(0, 1'b1, 1'b0, 11'h7FF, '0);
        mon();
        chk("T4_we_pulse", {31'd0, bram_we}, 32'd1);
        chk("T4_gnt0", {31'd0, bus.gnt0}, 32'd1);
        step();
        drive(0, 1'b0, 1'b0, '0, '0);
        mon();
        chk("T4_we_single", {31'd0, bram_we}, 32'd0);
        step();
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mon();
            if (bus.rvalid0) begin
                got = 1'b1;
                chk("T4_rdata", bus.rdata, 32'h1234_5678);
                break;
            end
            step();
        end
        chk("T4_rvalid_seen", {31'd0, got}, 32'd1);
        step();
        run(4);

        // T3: both requesters reading continuously alternate one grant per cycle
        drive(0, 1'b1, 1'b0, AW'($urandom_range(15)), '0);
        drive(1, 1'b1, 1'b0, AW'($urandom_range(15)), '0);
        prev_g0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mon();
            chk("T3_one_gnt", {30'd0, bus.gnt0, bus.gnt1}, bus.gnt0 ? 32'd2 : 32'd1);
            if (k > 0) chk("T3_alt", {31'd0, bus.gnt0}, {31'd0, ~prev_g0});
            prev_g0 = bus.gnt0;
            step();
            if (acc0) drive(0, 1'b1, 1'b0, AW'($urandom_range(15)), '0);
            if (acc1) drive(1, 1'b1, 1'b0, AW'($urandom_range(15)), '0);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        run(8);

        // Grant table from a fresh reset: first tie to req 0, idle cycles keep the pointer
        vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        vt[10] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vt[11] = '{1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        run(IC);
        for (int r = 0; r < 12; r++) begin
            drive(0, vt[r].r0, 1'b0, AW'($urandom_range(15)), '0);
            drive(1, vt[r].r1, 1'b0, AW'($urandom_range(15)), '0);
            mon();
            chk($sformatf("TBL%0d_gnt0", r), {31'd0, bus.gnt0}, {31'd0, vt[r].g0});
            chk($sformatf("TBL%0d_gnt1", r), {31'd0, bus.gnt1}, {31'd0, vt[r].g1});
            step();
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        run(8);

        // T6: req 0 alone for five grants, then a tie goes to req 1
        do_reset();
        drive(0, 1'b1, 1'b0, AW'($urandom_range(15)), '0);
        cnt = 0;
        for (int k = 0; k < 30 && cnt < 5; k++) begin
            mon();
            if (!bus.ready) chk("T6_no_gnt_init", {30'd0, bus.gnt0, bus.gnt1}, 32'd0);
            step();
            if (acc0) begin
                cnt++;
                drive(0, 1'b1, 1'b0, AW'($urandom_range(15)), '0);
            end
        end
        chk("T6_req0_grants", cnt, 32'd5);
        drive(1, 1'b1, 1'b0, AW'($urandom_range(15)), '0);
        mon();
        chk("T6_tie_gnt1", {31'd0, bus.gnt1}, 32'd1);
        chk("T6_tie_gnt0", {31'd0, bus.gnt0}, 32'd0);
        step();
        drive(1, 1'b0, 1'b0, '0, '0);
        mon();
        chk("T6_then_gnt0", {31'd0, bus.gnt0}, 32'd1);
        step();
        drive(0, 1'b0, 1'b0, '0, '0);
        run(8);

        // T5: reset one cycle after a read accept drops its response
        issue(0, 1'b0, 11'h003, '0);
        mon();
        step();
        reset_a = 1'b1;
        #1;
        chk("T5_we", {31'd0, bram_we}, 32'd0);
        chk("T5_ready_rst", {31'd0, bus.ready}, 32'd0);
        mon();
        step();
        mon();
        step();
        reset_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mon();
            chk("T5_no_rvalid", {30'd0, bus.rvalid0, bus.rvalid1}, 32'd0);
            chk("T5_ready", {31'd0, bus.ready}, (k >= IC) ? 32'd1 : 32'd0);
            step();
        end

        // Reset during a write pulse clears bram_we at once (data rewritten unchanged)
        issue(1, 1'b1, 11'h004, smem[4]);
        chk("T5w_we_before", {31'd0, bram_we}, 32'd1);
        reset_a = 1'b1;
        #1;
        chk("T5w_we_cleared", {31'd0, bram_we}, 32'd0);
        mon();
        step();
        reset_a = 1'b0;
        run(IC + 1);

        // Random traffic against the scoreboard, including legal qualifier changes
        rq_on[0] = 1'b0;
        rq_on[1] = 1'b0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ((i == 0 && acc0) || (i == 1 && acc1)) rq_on[i] = 1'b0;
                if ((!rq_on[i] && $urandom_range(2) == 0) || (rq_on[i] && $urandom_range(7) == 0)) begin
                    ra = ($urandom_range(7) == 0) ? 11'h7FF : AW'($urandom_range(15));
                    rq_on[i] = 1'b1;
                    drive(i, 1'b1, ($urandom_range(2) == 0), ra, $urandom);
                end else if (!rq_on[i]) begin
                    drive(i, 1'b0, 1'b0, '0, '0);
                end
            end
            mon();
            step();
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        run(8);
        chk("drain_empty", rq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
